// File: rtl/error_monitor_pkg.sv
// Shared types and width helpers for the error monitor: the FSM encoding and
// the derived widths of the error, per-sample sum and epoch accumulator.
package error_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int err_w(input int act_w);
        return act_w + 1;
    endfunction

    function automatic int sum_w(input int neurons, input int act_w);
        return err_w(act_w) + clog2(neurons);
    endfunction

    function automatic int acc_w(input int neurons, input int act_w, input int addr_w);
        return sum_w(neurons, act_w) + addr_w;
    endfunction

endpackage

// File: rtl/error_monitor_abs_sum_tree.sv
// Two-stage pipeline: register per-channel magnitudes, then register their
// exact sum. A valid bit travels alongside the data.
module abs_sum_tree
    import error_monitor_pkg::*;
#(
    parameter int NEURON_NUM = 4,
    parameter int E          = 33,
    parameter int SUM_W      = E + clog2(NEURON_NUM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NEURON_NUM*E-1:0] i_data,
    input  logic                    i_valid,
    output logic [SUM_W-1:0]        o_sum,
    output logic                    o_valid
);

    logic [E-1:0]     w_mag [NEURON_NUM];
    logic [E-1:0]     r_mag [NEURON_NUM];
    logic [SUM_W-1:0] w_total;
    logic [SUM_W-1:0] r_sum;
    logic             r_v1;
    logic             r_v2;

    // Two's-complement negate in E bits maps -2^(E-1) onto 2^(E-1) unsigned.
    always_comb begin
        for (int i = 0; i < NEURON_NUM; i++) begin
            w_mag[i] = i_data[i*E+E-1] ? (~i_data[i*E +: E] + E'(1)) : i_data[i*E +: E];
        end
    end

    always_comb begin
        w_total = '0;
        for (int i = 0; i < NEURON_NUM; i++) begin
            w_total = w_total + SUM_W'(r_mag[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_sum <= '0;
            for (int i = 0; i < NEURON_NUM; i++) r_mag[i] <= '0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            if (i_valid) begin
                for (int i = 0; i < NEURON_NUM; i++) r_mag[i] <= w_mag[i];
            end
            if (r_v1) r_sum <= w_total;
        end
    end

    assign o_sum   = r_sum;
    assign o_valid = r_v2;

endmodule

// File: rtl/error_monitor.sv
// Training-progress monitor: per-sample L1 error, its moving average, per-epoch
// sums and a sticky convergence flag after a streak of low-error epochs.
module error_monitor
    import error_monitor_pkg::*;
#(
    parameter int NEURON_NUM         = 4,
    parameter int ACTIVATION_WIDTH   = 32,
    parameter int DATASET_ADDR_WIDTH = 8,
    parameter int MAX_SAMPLES        = 150,
    parameter int AVG_SHIFT          = 4,
    parameter int AVG_INIT           = 10000,
    parameter int PATIENCE           = 3,
    parameter int EPOCH_WIDTH        = 16,
    localparam int E     = err_w(ACTIVATION_WIDTH),
    localparam int SUM_W = sum_w(NEURON_NUM, ACTIVATION_WIDTH),
    localparam int ACC_W = acc_w(NEURON_NUM, ACTIVATION_WIDTH, DATASET_ADDR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NEURON_NUM*E-1:0] error,
    input  logic                    error_valid,
    output logic                    error_ready,
    input  logic [ACC_W-1:0]        threshold,
    input  logic                    clear,
    output logic [SUM_W-1:0]        sample_sum,
    output logic                    sample_sum_valid,
    output logic [SUM_W-1:0]        average,
    output logic [ACC_W-1:0]        epoch_sum,
    output logic                    epoch_valid,
    output logic [EPOCH_WIDTH-1:0]  epoch_count,
    output logic                    converged,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = DATASET_ADDR_WIDTH;
    localparam int PAT_W = clog2(PATIENCE + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_SAMPLES - 1);
    localparam logic [PAT_W-1:0] PAT  = PAT_W'(PATIENCE);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_flush;
    logic [CNT_W-1:0]       r_cnt;
    logic [ACC_W-1:0]       r_acc;
    logic [SUM_W-1:0]       r_avg;
    logic [ACC_W-1:0]       r_epoch_sum;
    logic                   r_epoch_valid;
    logic [EPOCH_WIDTH-1:0] r_epoch_count;
    logic [PAT_W-1:0]       r_streak;
    logic [PAT_W-1:0]       w_streak_next;
    logic                   r_converged;
    logic                   w_fire;
    logic                   w_last;
    logic                   w_report;
    logic [SUM_W-1:0]       w_sum;
    logic                   w_sum_valid;

    assign error_ready = (r_state == ST_ACCUM) && !rst;
    assign w_fire      = error_valid && error_ready;
    assign w_last      = (r_cnt == LAST);
    assign w_report    = (r_state == ST_REPORT);

    abs_sum_tree #(
        .NEURON_NUM (NEURON_NUM),
        .E          (E),
        .SUM_W      (SUM_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_data  (error),
        .i_valid (w_fire),
        .o_sum   (w_sum),
        .o_valid (w_sum_valid)
    );

    // FLUSH lasts two cycles so the last sample reaches acc before REPORT reads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_flush <= (r_state == ST_FLUSH) ? ~r_flush : 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM:  if (w_fire && w_last) w_state_next = ST_FLUSH;
            ST_FLUSH:  if (r_flush) w_state_next = ST_REPORT;
            ST_REPORT: w_state_next = ST_ACCUM;
            default:   w_state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_avg <= SUM_W'(AVG_INIT);
            r_acc <= '0;
        end else begin
            if (w_fire) r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_sum_valid) r_avg <= r_avg - (r_avg >> AVG_SHIFT) + (w_sum >> AVG_SHIFT);
            if (w_report) r_acc <= '0;
            else if (w_sum_valid) r_acc <= r_acc + ACC_W'(w_sum);
        end
    end

    always_comb begin
        w_streak_next = '0;
        if (r_acc < threshold) begin
            w_streak_next = (r_streak == PAT) ? r_streak : r_streak + PAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_epoch_sum   <= '0;
            r_epoch_valid <= 1'b0;
            r_epoch_count <= '0;
            r_streak      <= '0;
            r_converged   <= 1'b0;
        end else begin
            r_epoch_valid <= w_report;
            if (w_report) begin
                r_epoch_sum   <= r_acc;
                r_epoch_count <= r_epoch_count + EPOCH_WIDTH'(1);
            end
            if (clear) begin
                r_streak    <= '0;
                r_converged <= 1'b0;
            end else if (w_report) begin
                r_streak <= w_streak_next;
                if (w_streak_next == PAT) r_converged <= 1'b1;
            end
        end
    end

    assign sample_sum       = w_sum;
    assign sample_sum_valid = w_sum_valid;
    assign average          = r_avg;
    assign epoch_sum        = r_epoch_sum;
    assign epoch_valid      = r_epoch_valid;
    assign epoch_count      = r_epoch_count;
    assign converged        = r_converged;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_error_monitor.sv
// Bench for error_monitor: a 3-sample-epoch instance for the main function and
// a 1-sample-epoch instance with no averaging for the back-pressure corner.
module tb_error_monitor;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int E     = AW + 1;
    localparam int SUM_W = E + 2;
    localparam int DW    = 8;
    localparam int ACC_W = SUM_W + DW;
    localparam int EW    = 16;
    localparam int MAXS  = 3;
    localparam int PAT   = 3;
    localparam int SHIFT = 4;
    localparam int INIT  = 10000;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [EW-1:0]    cnt;
        logic             conv;
    } epoch_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*E-1:0]   error = '0;
    logic             error_valid = 1'b0;
    logic             error_ready;
    logic [ACC_W-1:0] threshold = '0;
    logic             clear = 1'b0;
    logic [SUM_W-1:0] sample_sum;
    logic             sample_sum_valid;
    logic [SUM_W-1:0] average;
    logic [ACC_W-1:0] epoch_sum;
    logic             epoch_valid;
    logic [EW-1:0]    epoch_count;
    logic             converged;
    logic [1:0]       dbg_state;

    logic [N*E-1:0]   error2 = '0;
    logic             error_valid2 = 1'b0;
    logic             error_ready2;
    logic [SUM_W-1:0] sample_sum2;
    logic             sample_sum_valid2;
    logic [SUM_W-1:0] average2;
    logic [ACC_W-1:0] epoch_sum2;
    logic             epoch_valid2;
    logic [EW-1:0]    epoch_count2;
    logic             converged2;
    logic [1:0]       dbg_state2;

    error_monitor #(
        .NEURON_NUM(N), .ACTIVATION_WIDTH(AW), .DATASET_ADDR_WIDTH(DW),
        .MAX_SAMPLES(MAXS), .AVG_SHIFT(SHIFT), .AVG_INIT(INIT),
        .PATIENCE(PAT), .EPOCH_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst), .error(error), .error_valid(error_valid),
        .error_ready(error_ready), .threshold(threshold), .clear(clear),
        .sample_sum(sample_sum), .sample_sum_valid(sample_sum_valid),
        .average(average), .epoch_sum(epoch_sum), .epoch_valid(epoch_valid),
        .epoch_count(epoch_count), .converged(converged), .dbg_state(dbg_state)
    );

    error_monitor #(
        .NEURON_NUM(N), .ACTIVATION_WIDTH(AW), .DATASET_ADDR_WIDTH(DW),
        .MAX_SAMPLES(1), .AVG_SHIFT(0), .AVG_INIT(INIT),
        .PATIENCE(PAT), .EPOCH_WIDTH(EW)
    ) dut2 (
        .clk(clk), .rst(rst), .error(error2), .error_valid(error_valid2),
        .error_ready(error_ready2), .threshold('0), .clear(1'b0),
        .sample_sum(sample_sum2), .sample_sum_valid(sample_sum_valid2),
        .average(average2), .epoch_sum(epoch_sum2), .epoch_valid(epoch_valid2),
        .epoch_count(epoch_count2), .converged(converged2), .dbg_state(dbg_state2)
    );

    logic [SUM_W-1:0] exp_sum_q[$];
    logic [SUM_W-1:0] exp_avg_q[$];
    epoch_t           exp_ep_q[$];
    logic [SUM_W-1:0] exp_sum2_q[$];
    logic [ACC_W-1:0] exp_ep2_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [SUM_W-1:0] m_avg = SUM_W'(INIT);
    logic [ACC_W-1:0] m_acc = '0;
    int               m_cnt = 0;
    int               m_epochs = 0;
    int               m_streak = 0;
    bit               m_conv = 1'b0;
    bit               clear_at_report = 1'b0;
    int               waits;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT output with nothing expected", name);
    endtask

    function automatic logic [E-1:0] ev(input int x);
        return E'(x);
    endfunction

    // ---------------- monitors ----------------
    logic [SUM_W-1:0] avg_hold;
    bit               avg_pending = 1'b0;
    logic [SUM_W-1:0] avg2_hold;
    bit               avg2_pending = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            avg_pending  = 1'b0;
            avg2_pending = 1'b0;
        end else begin
            if (avg_pending) begin
                check("average", average, avg_hold);
                avg_pending = 1'b0;
            end
            if (sample_sum_valid) begin
                if (exp_sum_q.size() == 0) unexpected("sample_sum_valid");
                else begin
                    check("sample_sum", sample_sum, exp_sum_q.pop_front());
                    avg_hold    = exp_avg_q.pop_front();
                    avg_pending = 1'b1;
                end
            end
            if (epoch_valid) begin
                if (exp_ep_q.size() == 0) unexpected("epoch_valid");
                else begin
                    epoch_t e;
                    e = exp_ep_q.pop_front();
                    check("epoch_sum", epoch_sum, e.sum);
                    check("epoch_count", epoch_count, e.cnt);
                    check("converged", converged, e.conv);
                end
            end
            if (avg2_pending) begin
                check("average2", average2, avg2_hold);
                avg2_pending = 1'b0;
            end
            if (sample_sum_valid2) begin
                if (exp_sum2_q.size() == 0) unexpected("sample_sum_valid2");
                else begin
                    avg2_hold = exp_sum2_q.pop_front();
                    check("sample_sum2", sample_sum2, avg2_hold);
                    avg2_pending = 1'b1;
                end
            end
            if (epoch_valid2) begin
                if (exp_ep2_q.size() == 0) unexpected("epoch_valid2");
                else check("epoch_sum2", epoch_sum2, exp_ep2_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Called mid-cycle; holds error_valid until accepted, returns at the next negedge.
    task automatic send(input logic [E-1:0] a, input logic [E-1:0] b, input logic [E-1:0] c,
                        input logic [E-1:0] d, input logic [SUM_W-1:0] exp, output int nw);
        error       = {d, c, b, a};
        error_valid = 1'b1;
        nw = 0;
        while (!error_ready && nw < 20) begin
            @(negedge clk);
            nw++;
        end
        if (nw >= 20) begin
            unexpected("send_timeout");
            error_valid = 1'b0;
        end else begin
            exp_sum_q.push_back(exp);
            m_avg = m_avg - (m_avg >> SHIFT) + (exp >> SHIFT);
            exp_avg_q.push_back(m_avg);
            m_acc = m_acc + ACC_W'(exp);
            m_cnt++;
            if (m_cnt == MAXS) begin
                epoch_t e;
                m_cnt = 0;
                m_epochs++;
                if (clear_at_report) begin
                    m_streak = 0;
                    m_conv   = 1'b0;
                end else begin
                    if (m_acc < threshold) m_streak = (m_streak == PAT) ? PAT : m_streak + 1;
                    else m_streak = 0;
                    if (m_streak == PAT) m_conv = 1'b1;
                end
                e.sum  = m_acc;
                e.cnt  = EW'(m_epochs);
                e.conv = m_conv;
                exp_ep_q.push_back(e);
                m_acc = '0;
            end
            @(posedge clk);
            #1 error_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send2(input int val, output int nw);
        error2        = '0;
        error2[E-1:0] = ev(val);
        error_valid2  = 1'b1;
        nw = 0;
        while (!error_ready2 && nw < 20) begin
            @(negedge clk);
            nw++;
        end
        if (nw >= 20) begin
            unexpected("send2_timeout");
            error_valid2 = 1'b0;
        end else begin
            exp_sum2_q.push_back(SUM_W'(val));
            exp_ep2_q.push_back(ACC_W'(val));
            @(posedge clk);
            #1 error_valid2 = 1'b0;
            @(negedge clk);
        end
    endtask

    // Three samples: 10, 10, then 10 or 20. With clr, clear lands on the REPORT cycle.
    task automatic epoch_run(input bit last20, input bit clr);
        int nw;
        send(ev(5), ev(-3), ev(2), ev(0), 35'd10, nw);
        send(ev(5), ev(-3), ev(2), ev(0), 35'd10, nw);
        clear_at_report = clr;
        if (last20) send(ev(-10), ev(5), ev(-5), ev(0), 35'd20, nw);
        else send(ev(5), ev(-3), ev(2), ev(0), 35'd10, nw);
        clear_at_report = 1'b0;
        if (clr) begin
            @(negedge clk);
            @(negedge clk);
            clear = 1'b1;
            @(posedge clk);
            #1 clear = 1'b0;
        end
    endtask

    task automatic reset_and_check();
        @(posedge clk);
        #1 rst = 1'b1;
        exp_sum_q.delete();
        exp_avg_q.delete();
        exp_ep_q.delete();
        m_avg = SUM_W'(INIT);
        m_acc = '0;
        m_cnt = 0;
        m_epochs = 0;
        m_streak = 0;
        m_conv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_error_ready", error_ready, 0);
        check("rst_sample_sum", sample_sum, 0);
        check("rst_sample_valid", sample_sum_valid, 0);
        check("rst_average", average, INIT);
        check("rst_epoch_sum", epoch_sum, 0);
        check("rst_epoch_valid", epoch_valid, 0);
        check("rst_epoch_count", epoch_count, 0);
        check("rst_converged", converged, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", error_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [E-1:0] negmax;
        negmax = {1'b1, {AW{1'b0}}};

        reset_and_check();

        // Epoch 1: constant 160 drives the EMA (first value 9385).
        send(ev(40), ev(-40), ev(40), ev(-40), 35'd160, waits);
        check("waits_first", waits, 0);
        send(ev(40), ev(-40), ev(40), ev(-40), 35'd160, waits);
        check("waits_back_to_back", waits, 0);
        send(ev(40), ev(-40), ev(40), ev(-40), 35'd160, waits);

        // Epoch 2: most negative input; first accept waits out FLUSH+REPORT.
        send(ev(5), ev(-3), ev(0), negmax, 35'd4294967304, waits);
        check("waits_epoch_boundary", waits, 3);
        send(ev(1), ev(-1), ev(1), ev(-1), 35'd4, waits);
        send(ev(-7), ev(7), ev(0), ev(0), 35'd14, waits);

        // Convergence: sums 30,30,40,30,30,30 with clear on the sixth REPORT.
        threshold = ACC_W'(31);
        epoch_run(1'b0, 1'b0);
        epoch_run(1'b0, 1'b0);
        epoch_run(1'b1, 1'b0);
        epoch_run(1'b0, 1'b0);
        epoch_run(1'b0, 1'b0);
        epoch_run(1'b0, 1'b1);
        // Three more low epochs rebuild the streak and set converged.
        epoch_run(1'b0, 1'b0);
        epoch_run(1'b0, 1'b0);
        epoch_run(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("converged_set", converged, 1);

        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        m_conv = 1'b0;
        m_streak = 0;
        @(negedge clk);
        check("converged_after_clear", converged, 0);

        // Single-sample epochs under continuous valid.
        send2(7, waits);
        send2(100, waits);
        check("waits2_a", waits, 3);
        send2(4660, waits);
        check("waits2_b", waits, 3);
        repeat (6) @(negedge clk);
        check("epoch_count2", epoch_count2, 3);

        // Reset after two of three samples; partial epoch must vanish.
        send(ev(5), ev(-3), ev(2), ev(0), 35'd10, waits);
        send(ev(5), ev(-3), ev(2), ev(0), 35'd10, waits);
        repeat (4) @(negedge clk);
        reset_and_check();
        epoch_run(1'b0, 1'b0);

        repeat (8) @(negedge clk);
        check("sum_queue_drained", exp_sum_q.size(), 0);
        check("epoch_queue_drained", exp_ep_q.size(), 0);
        check("epoch2_queue_drained", exp_ep2_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
